// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// State encoding, funct3 width codes, fault causes, request legality check.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_R,
      DONE
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] C_NONE    = 2'b00;
   localparam logic [1:0] C_MISAL   = 2'b01;
   localparam logic [1:0] C_ILLEGAL = 2'b10;
   localparam logic [1:0] C_TIMEOUT = 2'b11;

   // Illegal width takes priority over misalignment.
   function automatic logic [1:0] req_check(
      input logic       we,
      input logic [2:0] f3,
      input logic [1:0] off
   );
      logic legal;
      logic misal;
      legal = 1'b0;
      misal = 1'b0;
      case (f3)
         F3_B:  legal = 1'b1;
         F3_H:  begin legal = 1'b1; misal = off[0]; end
         F3_W:  begin legal = 1'b1; misal = |off; end
         F3_BU: legal = ~we;
         F3_HU: begin legal = ~we; misal = off[0]; end
         default: legal = 1'b0;
      endcase
      if (!legal)
         return C_ILLEGAL;
      return misal ? C_MISAL : C_NONE;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: byte enables, store data replication, load extraction.
// In: funct3, off (addr[1:0]), wdata, rdata. Out: be, wdata_rep, ld_ext.
module lsu_lane import lsu_pkg::*; (
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] ld_ext
);

   logic [7:0]  lb;
   logic [15:0] lh;

   always_comb begin
      lb        = rdata[{off, 3'b000} +: 8];
      lh        = off[1] ? rdata[31:16] : rdata[15:0];
      be        = 4'b1111;
      wdata_rep = wdata;
      ld_ext    = rdata;
      case (funct3[1:0])
         2'b00: begin
            be        = 4'b0001 << off;
            wdata_rep = {4{wdata[7:0]}};
         end
         2'b01: begin
            be        = 4'b0011 << {off[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         default: ;
      endcase
      case (funct3)
         F3_B:    ld_ext = {{24{lb[7]}}, lb};
         F3_BU:   ld_ext = {24'b0, lb};
         F3_H:    ld_ext = {{16{lh[15]}}, lh};
         F3_HU:   ld_ext = {16'b0, lh};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: core request -> req/ready + rvalid memory handshake.
// Core side: req_*, stall, ld_valid/ld_data, fault/fault_cause. Memory side: mem_*.
module lsu import lsu_pkg::*; #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   state_t        state, state_n;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [1:0]    cause_q;
   logic [CW-1:0] cnt;
   logic [1:0]    req_cause;
   logic          expired;
   logic [3:0]    be;
   logic [31:0]   wrep;
   logic [31:0]   ld_ext;

   assign req_cause = req_check(req_we, req_funct3, req_addr[1:0]);
   assign expired   = (cnt == CW'(TIMEOUT - 1));

   // Reset gating keeps stall low while reset is held.
   assign stall = req_valid & (state != DONE) & ~reset;

   lsu_lane u_lane (
      .funct3    (f3_q),
      .off       (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata     (mem_rdata),
      .be        (be),
      .wdata_rep (wrep),
      .ld_ext    (ld_ext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n     = state;
      ld_valid    = 1'b0;
      fault       = 1'b0;
      fault_cause = C_NONE;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_be      = 4'b0;
      mem_addr    = 32'b0;
      mem_wdata   = 32'b0;
      unique case (state)
         IDLE: begin
            if (req_valid)
               state_n = (req_cause != C_NONE) ? DONE : REQ;
         end
         REQ: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_be    = be;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wdata = wrep;
            if (mem_ready)
               state_n = we_q ? DONE : WAIT_R;
            else if (expired)
               state_n = DONE;
         end
         WAIT_R: begin
            if (mem_rvalid || expired)
               state_n = DONE;
         end
         DONE: begin
            state_n     = IDLE;
            fault       = (cause_q != C_NONE);
            fault_cause = cause_q;
            ld_valid    = ~we_q & (cause_q == C_NONE);
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b0;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         cause_q <= C_NONE;
         cnt     <= '0;
         ld_data <= 32'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  cause_q <= req_cause;
                  cnt     <= '0;
               end
            end
            REQ: begin
               cnt <= cnt + 1'b1;
               if (!mem_ready && expired) begin
                  cause_q <= C_TIMEOUT;
                  ld_data <= 32'b0;
               end
            end
            WAIT_R: begin
               cnt <= cnt + 1'b1;
               if (mem_rvalid) begin
                  ld_data <= ld_ext;
               end else if (expired) begin
                  cause_q <= C_TIMEOUT;
                  ld_data <= 32'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus random ops.
// Expected values come from an arithmetic model of the access rules.
module tb_lsu;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        fault;
   logic [1:0]  fault_cause;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int          o_stalls, o_reqcyc, o_done_cyc;
   logic [31:0] o_addr, o_wdata, o_ld;
   logic [3:0]  o_be;
   logic [1:0]  o_cause;
   logic        o_we, o_ldv, o_fault, o_hang;
   logic        o_leak, o_early, o_after, o_req_done;

   lsu #(.TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .stall       (stall),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .fault       (fault),
      .fault_cause (fault_cause),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ready   (mem_ready),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- reference model ----------------
   function automatic int m_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [1:0] m_cause(input logic we,
                                          input logic [2:0] f3,
                                          input logic [31:0] a);
      int s;
      if (f3 == 3 || f3 > 5 || (we && f3 > 2)) return 2'd2;
      s = m_size(f3);
      if (int'(a[1:0]) % s != 0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3,
                                       input logic [31:0] a);
      int v;
      v = ((1 << m_size(f3)) - 1) << a[1:0];
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                        input logic [31:0] wd);
      if (m_size(f3) == 1) return {24'b0, wd[7:0]} * 32'h01010101;
      if (m_size(f3) == 2) return {16'b0, wd[15:0]} * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] m_ld(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] rd);
      int s;
      logic [31:0] mask, v;
      s = m_size(f3);
      if (s == 4) return rd;
      mask = (32'd1 << (8 * s)) - 1;
      v = (rd >> (8 * a[1:0])) & mask;
      if (f3 < 4 && v[8 * s - 1]) v = v | ~mask;
      return v;
   endfunction

   // Drives one request and acts as memory; records what it saw.
   task automatic run_op(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int rdy,
                         input int rvd, input logic stray);
      int nreq, acc;
      bit accepted, done;
      nreq = 0; acc = 0; accepted = 0; done = 0;
      o_stalls = 0; o_leak = 0; o_early = 0; o_hang = 0;
      o_addr = 0; o_be = 0; o_wdata = 0; o_we = 0;
      o_ldv = 0; o_ld = 0; o_fault = 0; o_cause = 0;
      o_req_done = 0; o_done_cyc = 0;
      req_valid = 1; req_we = we; req_funct3 = f3;
      req_addr = a; req_wdata = wd;
      for (int c = 0; c < 100 && !done; c++) begin
         #1;
         if (!mem_req && (mem_we || mem_be != 0 ||
             mem_addr != 0 || mem_wdata != 0))
            o_leak = 1;
         if (stall) begin
            o_stalls++;
            if (ld_valid || fault) o_early = 1;
         end else begin
            done = 1;
            o_ldv = ld_valid; o_ld = ld_data;
            o_fault = fault; o_cause = fault_cause;
            o_req_done = mem_req; o_done_cyc = cyc;
         end
         mem_ready = 0; mem_rvalid = 0; mem_rdata = $urandom;
         if (!done) begin
            if (mem_req) begin
               if (nreq == 0) begin
                  o_addr = mem_addr; o_be = mem_be;
                  o_wdata = mem_wdata; o_we = mem_we;
               end
               nreq++;
               if (nreq > rdy && !accepted) begin
                  mem_ready = 1; accepted = 1; acc = c;
               end
               mem_rvalid = stray;
            end else if (accepted && c == acc + rvd) begin
               mem_rvalid = 1; mem_rdata = rd;
            end
         end
         @(negedge clk);
      end
      if (!done) o_hang = 1;
      o_reqcyc = nreq;
      req_valid = 0; mem_ready = 0; mem_rvalid = 0;
      #1;
      o_after = ld_valid | fault | stall | mem_req;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      reset = 1; req_valid = 1; req_we = 0; req_funct3 = 3'b010;
      req_addr = 32'h0; req_wdata = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      @(negedge clk); #1;
      checks++;
      if ({stall, ld_valid, fault, fault_cause, mem_req, mem_we,
           mem_be, mem_addr, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got stall=%b req=%b be=%b want all 0",
                  stall, mem_req, mem_be);
      end
      checks++;
      if (ld_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_ld_data got %h want 0", ld_data);
      end
      req_valid = 0;
      @(negedge clk);
      reset = 0;
      @(negedge clk);
   endtask

   task automatic test_store;
      run_op(1, 3'b000, 32'h103, 32'hA5, 0, 0, 1, 0);
      checks++;
      if (o_addr !== 32'h100) begin
         errors++; $display("FAIL sb_addr got %h want 100", o_addr);
      end
      checks++;
      if (o_be !== 4'b1000) begin
         errors++; $display("FAIL sb_be got %b want 1000", o_be);
      end
      checks++;
      if (o_wdata !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", o_wdata);
      end
      checks++;
      if (o_we !== 1'b1) begin
         errors++; $display("FAIL sb_we got %b want 1", o_we);
      end
      checks++;
      if (o_stalls != 2) begin
         errors++; $display("FAIL sb_stalls got %0d want 2", o_stalls);
      end
      checks++;
      if (o_fault !== 0 || o_ldv !== 0 || o_after !== 0) begin
         errors++;
         $display("FAIL sb_flags got fault=%b ldv=%b after=%b want 0",
                  o_fault, o_ldv, o_after);
      end
   endtask

   task automatic test_load;
      run_op(0, 3'b000, 32'h102, 0, 32'h12F45678, 0, 3, 1);
      checks++;
      if (o_ld !== 32'hFFFFFFF4 || o_ldv !== 1'b1) begin
         errors++;
         $display("FAIL lb_data got %h v=%b want fffffff4 v=1", o_ld, o_ldv);
      end
      checks++;
      if (o_after !== 1'b0) begin
         errors++; $display("FAIL lb_pulse got after=%b want 0", o_after);
      end
      checks++;
      if (o_stalls != 5 || o_be !== 4'b0100 || o_we !== 0) begin
         errors++;
         $display("FAIL lb_req got stalls=%0d be=%b we=%b want 5 0100 0",
                  o_stalls, o_be, o_we);
      end
      run_op(0, 3'b100, 32'h102, 0, 32'h12F45678, 0, 1, 0);
      checks++;
      if (o_ld !== 32'h000000F4 || o_ldv !== 1'b1) begin
         errors++;
         $display("FAIL lbu_data got %h v=%b want 000000f4 v=1", o_ld, o_ldv);
      end
      checks++;
      if (o_stalls != 3) begin
         errors++; $display("FAIL lbu_stalls got %0d want 3", o_stalls);
      end
   endtask

   task automatic test_misaligned;
      run_op(0, 3'b001, 32'h201, 0, 0, 0, 1, 0);
      checks++;
      if (o_fault !== 1 || o_cause !== 2'b01 || o_ldv !== 0) begin
         errors++;
         $display("FAIL lh_misal got f=%b c=%b v=%b want 1 01 0",
                  o_fault, o_cause, o_ldv);
      end
      checks++;
      if (o_reqcyc != 0 || o_stalls != 1 || o_leak !== 0) begin
         errors++;
         $display("FAIL lh_misal_mem got req=%0d stalls=%0d want 0 1",
                  o_reqcyc, o_stalls);
      end
      run_op(1, 3'b010, 32'h302, 32'h1, 0, 0, 1, 0);
      checks++;
      if (o_cause !== 2'b01 || o_reqcyc != 0) begin
         errors++;
         $display("FAIL sw_misal got c=%b req=%0d want 01 0", o_cause, o_reqcyc);
      end
   endtask

   task automatic test_illegal;
      run_op(0, 3'b011, 32'h0, 0, 0, 0, 1, 0);
      checks++;
      if (o_fault !== 1 || o_cause !== 2'b10 || o_stalls != 1) begin
         errors++;
         $display("FAIL f3_011 got f=%b c=%b st=%0d want 1 10 1",
                  o_fault, o_cause, o_stalls);
      end
      run_op(1, 3'b100, 32'h0, 0, 0, 0, 1, 0);
      checks++;
      if (o_cause !== 2'b10 || o_reqcyc != 0) begin
         errors++;
         $display("FAIL store_bu got c=%b req=%0d want 10 0", o_cause, o_reqcyc);
      end
   endtask

   task automatic test_timeout;
      run_op(1, 3'b010, 32'h40, 32'h9, 0, 1000, 1, 0);
      checks++;
      if (o_fault !== 1 || o_cause !== 2'b11) begin
         errors++;
         $display("FAIL sw_tmo got f=%b c=%b want 1 11", o_fault, o_cause);
      end
      checks++;
      if (o_stalls != TO + 1 || o_reqcyc != TO || o_req_done !== 0) begin
         errors++;
         $display("FAIL sw_tmo_len got st=%0d req=%0d rd=%b want %0d %0d 0",
                  o_stalls, o_reqcyc, o_req_done, TO + 1, TO);
      end
      run_op(1, 3'b010, 32'h40, 32'h9, 0, TO - 1, 1, 0);
      checks++;
      if (o_fault !== 0 || o_stalls != TO + 1) begin
         errors++;
         $display("FAIL sw_edge got f=%b st=%0d want 0 %0d",
                  o_fault, o_stalls, TO + 1);
      end
      run_op(0, 3'b010, 32'h44, 0, 32'h7, 0, TO - 1, 0);
      checks++;
      if (o_fault !== 0 || o_ld !== 32'h7 || o_ldv !== 1) begin
         errors++;
         $display("FAIL lw_edge got f=%b d=%h v=%b want 0 7 1",
                  o_fault, o_ld, o_ldv);
      end
      run_op(0, 3'b010, 32'h48, 0, 32'h7, 0, TO, 0);
      checks++;
      if (o_cause !== 2'b11 || o_ld !== 0 || o_ldv !== 0) begin
         errors++;
         $display("FAIL lw_tmo got c=%b d=%h v=%b want 11 0 0",
                  o_cause, o_ld, o_ldv);
      end
   endtask

   task automatic test_reset_mid;
      req_valid = 1; req_we = 0; req_funct3 = 3'b010;
      req_addr = 32'h40; req_wdata = 0;
      mem_ready = 1; mem_rvalid = 0;
      @(negedge clk);
      @(negedge clk);
      mem_ready = 0;
      #1;
      checks++;
      if (stall !== 1 || mem_req !== 0) begin
         errors++;
         $display("FAIL mid_wait got stall=%b req=%b want 1 0", stall, mem_req);
      end
      reset = 1;
      #1;
      checks++;
      if ({stall, ld_valid, fault, fault_cause, mem_req, mem_we,
           mem_be, mem_addr, mem_wdata, ld_data} !== '0) begin
         errors++;
         $display("FAIL mid_reset got stall=%b req=%b ld=%h want all 0",
                  stall, mem_req, ld_data);
      end
      @(negedge clk);
      reset = 0; req_valid = 0;
      @(negedge clk);
      run_op(0, 3'b010, 32'h0, 0, 32'hDEADBEEF, 0, 1, 0);
      checks++;
      if (o_ld !== 32'hDEADBEEF || o_ldv !== 1 || o_stalls != 3) begin
         errors++;
         $display("FAIL post_reset_lw got %h v=%b st=%0d want deadbeef 1 3",
                  o_ld, o_ldv, o_stalls);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] held, ld1;
      int d1;
      held = ld_data;
      mem_rvalid = 1; mem_rdata = 32'h55555555;
      @(negedge clk); #1;
      checks++;
      if (ld_valid !== 0 || stall !== 0 || ld_data !== held) begin
         errors++;
         $display("FAIL stray_rvalid got v=%b d=%h want 0 %h",
                  ld_valid, ld_data, held);
      end
      mem_rvalid = 0;
      @(negedge clk);
      run_op(0, 3'b010, 32'h10, 0, 32'h11111111, 0, 1, 0);
      ld1 = o_ld; d1 = o_done_cyc;
      run_op(0, 3'b010, 32'h14, 0, 32'h22222222, 0, 1, 0);
      checks++;
      if (ld1 !== 32'h11111111 || o_ld !== 32'h22222222) begin
         errors++;
         $display("FAIL b2b_data got %h %h want 11111111 22222222", ld1, o_ld);
      end
      checks++;
      if (o_done_cyc - d1 != 4 || o_addr !== 32'h14) begin
         errors++;
         $display("FAIL b2b_gap got %0d addr=%h want 4 14",
                  o_done_cyc - d1, o_addr);
      end
   endtask

   task automatic test_random;
      logic        we, stray, tmo;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      logic [1:0]  ec;
      int rdy, rvd, n, est, ereq;
      for (int i = 0; i < 80; i++) begin
         we = 1'($urandom); f3 = 3'($urandom_range(0, 7));
         a = $urandom; wd = $urandom; rd = $urandom;
         rdy = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 3);
         rvd = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(1, 3);
         stray = 1'($urandom);
         ec = m_cause(we, f3, a);
         n = rdy + 1 + (we ? 0 : rvd);
         tmo = (ec == 0) && (n > TO);
         if (ec != 0) begin
            est = 1; ereq = 0;
         end else begin
            est = 1 + (tmo ? TO : n);
            ereq = (rdy + 1 > TO) ? TO : rdy + 1;
         end
         if (tmo) ec = 2'd3;
         run_op(we, f3, a, wd, rd, rdy, rvd, stray);
         checks++;
         if (o_hang || o_cause !== ec || o_fault !== (ec != 0)) begin
            errors++;
            $display("FAIL rnd%0d_cause got c=%b f=%b want %b", i,
                     o_cause, o_fault, ec);
         end
         checks++;
         if (o_stalls != est || o_reqcyc != ereq) begin
            errors++;
            $display("FAIL rnd%0d_timing got st=%0d req=%0d want %0d %0d",
                     i, o_stalls, o_reqcyc, est, ereq);
         end
         checks++;
         if (o_ldv !== (!we && ec == 0) || o_after || o_leak || o_early) begin
            errors++;
            $display("FAIL rnd%0d_flags got v=%b aft=%b lk=%b er=%b", i,
                     o_ldv, o_after, o_leak, o_early);
         end
         if (ereq > 0) begin
            checks++;
            if (o_addr !== (a & ~32'h3) || o_be !== m_be(f3, a) ||
                o_we !== we || (we && o_wdata !== m_wd(f3, wd))) begin
               errors++;
               $display("FAIL rnd%0d_mem got a=%h be=%b wd=%h want %h %b %h",
                        i, o_addr, o_be, o_wdata, a & ~32'h3,
                        m_be(f3, a), m_wd(f3, wd));
            end
         end
         if (!we && (ec == 0 || ec == 3)) begin
            checks++;
            if (o_ld !== ((ec == 3) ? 32'h0 : m_ld(f3, a, rd))) begin
               errors++;
               $display("FAIL rnd%0d_ld got %h want %h", i, o_ld,
                        (ec == 3) ? 32'h0 : m_ld(f3, a, rd));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_misaligned();
      test_illegal();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
